// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing constants and shared types for vga_sync_gen.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

    localparam int H_SYNC_START = H_VISIBLE_DEF + H_FRONT_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF;
    localparam int V_SYNC_START = V_VISIBLE_DEF + V_FRONT_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic video_on;
    } sync_t;

    localparam sync_t SYNC_RST = '{hsync_n: 1'b1, vsync_n: 1'b1, video_on: 1'b0};

    function automatic cnt_t to_cnt(input int v);
        return cnt_t'(v);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: wrapping position counter plus look-ahead sync/visible flags
// derived from the value the counter will hold after this edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = H_VISIBLE_DEF,
    parameter int FRONT   = H_FRONT_DEF,
    parameter int SYNC    = H_SYNC_DEF,
    parameter int BACK    = H_BACK_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output cnt_t count,
    output cnt_t next_count,
    output logic wrap,
    output logic sync_n_next,
    output logic visible_next
);

    localparam int   TOTAL      = VISIBLE + FRONT + SYNC + BACK;
    localparam cnt_t LAST       = to_cnt(TOTAL - 1);
    localparam cnt_t SYNC_START = to_cnt(VISIBLE + FRONT);
    localparam cnt_t SYNC_END   = to_cnt(VISIBLE + FRONT + SYNC);
    localparam cnt_t VIS_END    = to_cnt(VISIBLE);

    cnt_t r_count;
    cnt_t w_next;
    logic w_at_last;

    assign w_at_last = (r_count == LAST);
    assign wrap      = en & w_at_last;

    always_comb begin
        w_next = r_count;
        if (en) begin
            w_next = w_at_last ? '0 : r_count + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign count        = r_count;
    assign next_count   = w_next;
    assign sync_n_next  = !((w_next >= SYNC_START) && (w_next < SYNC_END));
    assign visible_next = (w_next < VIS_END);

endmodule

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA sync generator clocked at 50 MHz, advancing on pixel_tick.
// Define VGA_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_DEF,
    parameter int H_FRONT   = H_FRONT_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BACK    = H_BACK_DEF,
    parameter int V_VISIBLE = V_VISIBLE_DEF,
    parameter int V_FRONT   = V_FRONT_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BACK    = V_BACK_DEF
) (
    input  logic             Clck_in,
    input  logic             reset_Clock,
    input  logic             pixel_tick,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
   ,output logic [7:0]       frame_cnt
`endif
);

    cnt_t  w_h_cnt;
    cnt_t  w_h_next;
    cnt_t  w_v_cnt;
    cnt_t  w_v_next;
    logic  w_h_wrap;
    logic  w_v_wrap;
    logic  w_hs_n;
    logic  w_vs_n;
    logic  w_h_vis;
    logic  w_v_vis;
    logic  w_unused;
    sync_t w_sync_next;
    sync_t r_sync;
    logic  r_frame_start;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk          (Clck_in),
        .rst          (reset_Clock),
        .en           (pixel_tick),
        .count        (w_h_cnt),
        .next_count   (w_h_next),
        .wrap         (w_h_wrap),
        .sync_n_next  (w_hs_n),
        .visible_next (w_h_vis)
    );

    // The vertical axis steps only when the line ends.
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk          (Clck_in),
        .rst          (reset_Clock),
        .en           (w_h_wrap),
        .count        (w_v_cnt),
        .next_count   (w_v_next),
        .wrap         (w_v_wrap),
        .sync_n_next  (w_vs_n),
        .visible_next (w_v_vis)
    );

    assign w_unused = ^{w_h_next, w_v_next};

    always_comb begin
        w_sync_next          = SYNC_RST;
        w_sync_next.hsync_n  = w_hs_n;
        w_sync_next.vsync_n  = w_vs_n;
        w_sync_next.video_on = w_h_vis & w_v_vis;
    end

    always_ff @(posedge Clck_in) begin
        if (reset_Clock) begin
            r_sync        <= SYNC_RST;
            r_frame_start <= 1'b0;
        end else begin
            r_sync        <= w_sync_next;
            r_frame_start <= w_v_wrap;
        end
    end

    assign hsync       = r_sync.hsync_n;
    assign vsync       = r_sync.vsync_n;
    assign video_on    = r_sync.video_on;
    assign pixel_x     = w_h_cnt;
    assign pixel_y     = w_v_cnt;
    assign frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    // Counts on the same edge that raises frame_start.
    always_ff @(posedge Clck_in) begin
        if (reset_Clock) begin
            r_frame_cnt <= 8'd0;
        end else if (w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full 640x480 instance for line-level behaviour plus
// a shrunken-timing instance for frame-level behaviour, both checked every cycle.
module tb_vga_sync_gen;

    typedef struct packed {
        int   ht;
        int   vt;
        int   hv;
        int   hss;
        int   hse;
        int   vv;
        int   vss;
        int   vse;
        int   idx;
        int   fcnt;
        logic rstout;
        logic fs;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1;
    logic       tick_a = 1'b0;
    logic       rst_b = 1'b1;
    logic       tick_b = 1'b0;
    logic       hs_a, vs_a, vo_a, fs_a;
    logic       hs_b, vs_b, vo_b, fs_b;
    logic [9:0] px_a, py_a, px_b, py_b;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] fc_a, fc_b;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   chk_en = 1'b0;
    mdl_t ma;
    mdl_t mb;

    vga_sync_gen u_a (
        .Clck_in     (clk),
        .reset_Clock (rst_a),
        .pixel_tick  (tick_a),
        .hsync       (hs_a),
        .vsync       (vs_a),
        .video_on    (vo_a),
        .pixel_x     (px_a),
        .pixel_y     (py_a),
        .frame_start (fs_a)
`ifdef VGA_FRAME_CNT_EN
       ,.frame_cnt   (fc_a)
`endif
    );

    vga_sync_gen #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (3),
        .V_VISIBLE (6),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) u_b (
        .Clck_in     (clk),
        .reset_Clock (rst_b),
        .pixel_tick  (tick_b),
        .hsync       (hs_b),
        .vsync       (vs_b),
        .video_on    (vo_b),
        .pixel_x     (px_b),
        .pixel_y     (py_b),
        .frame_start (fs_b)
`ifdef VGA_FRAME_CNT_EN
       ,.frame_cnt   (fc_b)
`endif
    );

    function automatic mdl_t mk(input int hv, input int hf, input int hs, input int hb,
                                input int vv, input int vf, input int vs, input int vb);
        mdl_t m;
        m.ht     = hv + hf + hs + hb;
        m.vt     = vv + vf + vs + vb;
        m.hv     = hv;
        m.hss    = hv + hf;
        m.hse    = hv + hf + hs;
        m.vv     = vv;
        m.vss    = vv + vf;
        m.vse    = vv + vf + vs;
        m.idx    = 0;
        m.fcnt   = 0;
        m.rstout = 1'b1;
        m.fs     = 1'b0;
        return m;
    endfunction

    // Position is a linear pixel index within the frame.
    function automatic mdl_t step(input mdl_t m, input logic r, input logic t);
        mdl_t n;
        n = m;
        if (r) begin
            n.idx    = 0;
            n.fcnt   = 0;
            n.rstout = 1'b1;
            n.fs     = 1'b0;
        end else begin
            n.rstout = 1'b0;
            n.fs     = t && (m.idx == m.ht * m.vt - 1);
            if (t) n.idx = (m.idx + 1) % (m.ht * m.vt);
            if (n.fs) n.fcnt = (m.fcnt + 1) % 256;
        end
        return n;
    endfunction

    function automatic logic [23:0] expv(input mdl_t m);
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic vo;
        x  = m.idx % m.ht;
        y  = m.idx / m.ht;
        hs = m.rstout || !(x >= m.hss && x < m.hse);
        vs = m.rstout || !(y >= m.vss && y < m.vse);
        vo = !m.rstout && (x < m.hv) && (y < m.vv);
        return {hs, vs, vo, 10'(x), 10'(y), m.fs};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial begin
        ma = mk(640, 16, 96, 48, 480, 10, 2, 33);
        mb = mk(8, 2, 3, 3, 6, 1, 2, 1);
    end

    always @(posedge clk) begin
        cyc++;
        ma = step(ma, rst_a, tick_a);
        mb = step(mb, rst_b, tick_b);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_a", 32'({hs_a, vs_a, vo_a, px_a, py_a, fs_a}), 32'(expv(ma)));
            chk("cyc_b", 32'({hs_b, vs_b, vo_b, px_b, py_b, fs_b}), 32'(expv(mb)));
`ifdef VGA_FRAME_CNT_EN
            chk("fcnt_a", 32'(fc_a), 32'(ma.fcnt));
            chk("fcnt_b", 32'(fc_b), 32'(mb.fcnt));
`endif
        end
    end

    task automatic tick_a1();
        @(negedge clk);
        tick_a = 1'b1;
        @(negedge clk);
        tick_a = 1'b0;
    endtask

    task automatic tick_b1();
        @(negedge clk);
        tick_b = 1'b1;
        @(negedge clk);
        tick_b = 1'b0;
    endtask

    initial begin
        int hs_cnt;
        int hs_first;
        int vo_first;
        int ticks;
        int vlow;
        int vmin;
        int vmax;
        int t1;
        int t2;
        int nfs;
        int c;
        bit got;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tick_a = ~tick_a;
            tick_b = ~tick_b;
            if (i == 0) chk_en = 1'b1;
        end
        chk("rst_x", 32'(px_a), 0);
        chk("rst_y", 32'(py_a), 0);
        chk("rst_sync", 32'({hs_a, vs_a}), 3);
        chk("rst_vo", 32'(vo_a), 0);

        rst_a  = 1'b0;
        tick_a = 1'b0;
        tick_b = 1'b0;
        chk("rel_hold_vo", 32'(vo_a), 0);
        @(negedge clk);
        chk("rel_vo", 32'(vo_a), 1);
        chk("rel_xy", 32'({px_a, py_a}), 0);

        hs_cnt   = 0;
        hs_first = -1;
        vo_first = -1;
        for (int i = 1; i <= 800; i++) begin
            tick_a1();
            if (!hs_a) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(px_a);
            end
            if (!vo_a && vo_first < 0) vo_first = int'(px_a);
            if (i == 799) chk("line_end", 32'({px_a, py_a}), 32'({10'd799, 10'd0}));
            if (i == 800) chk("line_wrap", 32'({px_a, py_a}), 32'({10'd0, 10'd1}));
        end
        chk("hs_len", 32'(hs_cnt), 96);
        chk("hs_first", 32'(hs_first), 656);
        chk("vo_first", 32'(vo_first), 640);

        for (int i = 0; i < 300; i++) tick_a1();
        chk("pre_freeze_x", 32'(px_a), 300);
        repeat (100) @(negedge clk);
        chk("freeze_xy", 32'({px_a, py_a}), 32'({10'd300, 10'd1}));
        chk("freeze_flags", 32'({hs_a, vs_a, vo_a, fs_a}), 32'(4'b1110));
        tick_a1();
        chk("resume_x", 32'(px_a), 301);

        for (int i = 0; i < 399; i++) tick_a1();
        chk("pre_rst_a", 32'({px_a, hs_a}), 32'({10'd700, 1'b0}));
        rst_a  = 1'b1;
        tick_a = 1'b1;
        @(negedge clk);
        chk("mid_rst_a", 32'({px_a, py_a, hs_a, vs_a, vo_a, fs_a}), 32'({20'd0, 4'b1100}));
        rst_a  = 1'b0;
        tick_a = 1'b0;

        rst_b = 1'b0;
        @(negedge clk);
        chk("b_rel", 32'({px_b, py_b, vo_b}), 1);

        got   = 1'b0;
        ticks = 0;
        vlow  = 0;
        vmin  = 99;
        vmax  = -1;
        t1    = 0;
        for (int i = 1; i <= 400 && !got; i++) begin
            tick_b1();
            ticks = i;
            if (!vs_b) begin
                vlow++;
                if (int'(py_b) < vmin) vmin = int'(py_b);
                if (int'(py_b) > vmax) vmax = int'(py_b);
            end
            if (fs_b) begin
                got = 1'b1;
                t1  = cyc;
            end
        end
        chk("fs1_seen", 32'(got), 1);
        chk("fs1_ticks", 32'(ticks), 160);
        chk("vs_low_cnt", 32'(vlow), 32);
        chk("vs_low_range", 32'({vmin[7:0], vmax[7:0]}), 32'({8'd7, 8'd8}));

        got = 1'b0;
        t2  = 0;
        for (int i = 1; i <= 400 && !got; i++) begin
            tick_b1();
            ticks = i;
            if (fs_b) begin
                got = 1'b1;
                t2  = cyc;
            end
        end
        chk("fs2_seen", 32'(got), 1);
        chk("fs2_ticks", 32'(ticks), 160);
        chk("fs_period", 32'(t2 - t1), 320);
        chk("fs_xy", 32'({px_b, py_b}), 0);

        for (int i = 0; i < 123; i++) tick_b1();
        chk("pre_rst_b", 32'({px_b, py_b, hs_b, vs_b}), 32'({10'd11, 10'd7, 2'b00}));
        rst_b  = 1'b1;
        tick_b = 1'b1;
        @(negedge clk);
        chk("mid_rst_b", 32'({px_b, py_b, hs_b, vs_b, vo_b, fs_b}), 32'({20'd0, 4'b1100}));
        rst_b  = 1'b0;
        tick_b = 1'b0;
        @(negedge clk);
        chk("post_rst_b_fs", 32'(fs_b), 0);

        tick_b = 1'b1;
        nfs    = 0;
        c      = 0;
        t1     = 0;
        t2     = 0;
        while (nfs < 3 && c < 2000) begin
            @(negedge clk);
            c++;
            if (fs_b) begin
                nfs++;
                if (nfs == 1) t1 = cyc;
                if (nfs == 2) t2 = cyc;
            end
        end
        chk("fs_hi_cnt", 32'(nfs), 3);
        chk("fs_hi_per", 32'(t2 - t1), 160);
`ifdef VGA_FRAME_CNT_EN
        chk("fc_3", 32'(fc_b), 3);
        c = 0;
        while (nfs < 255 && c < 45000) begin
            @(negedge clk);
            c++;
            if (fs_b) nfs++;
        end
        chk("fc_255", 32'(fc_b), 255);
        c = 0;
        while (nfs < 256 && c < 400) begin
            @(negedge clk);
            c++;
            if (fs_b) nfs++;
        end
        chk("fc_256_cnt", 32'(nfs), 256);
        chk("fc_wrap", 32'(fc_b), 0);
`endif
        tick_b = 1'b0;
        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
